// File: rtl/axi4l_regbank.sv
// rtl/axi4l_regbank.sv - AXI4-Lite slave with NUM_RW control and NUM_RO status registers
module axi4l_regbank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_RW = 8,
  parameter int unsigned NUM_RO = 4,
  parameter logic [DATA_WIDTH-1:0] RST_VALUE = '0
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                   S_AXI_AWPROT,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                   S_AXI_ARPROT,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic [NUM_RW*DATA_WIDTH-1:0] rw_regs_o,
  output logic [NUM_RW-1:0]            wr_pulse_o,
  input  logic [NUM_RO*DATA_WIDTH-1:0] ro_regs_i
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [0:0]            w_state;
  logic [0:0]            r_state;
  logic                  aw_held;
  logic                  w_held;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic [DATA_WIDTH-1:0] regs [NUM_RW];
  logic [NUM_RW-1:0]     wr_pulse_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  wr_fire;
  logic                  wr_legal;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [NUM_RW-1:0]     wr_sel;
  logic [IDX_W-1:0]      ar_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_err;
  logic                  unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = !aw_held && (w_state == W_IDLE);
  assign S_AXI_WREADY  = !w_held && (w_state == W_IDLE);
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = (r_state == R_IDLE);
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign wr_pulse_o    = wr_pulse_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;

  // A held half takes priority; otherwise the half arriving this edge is used directly.
  assign wr_idx   = aw_held ? aw_idx_q : S_AXI_AWADDR[ADDR_WIDTH-1:2];
  assign wr_data  = w_held ? w_data_q : S_AXI_WDATA;
  assign wr_strb  = w_held ? w_strb_q : S_AXI_WSTRB;
  assign wr_fire  = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_legal = 32'(wr_idx) < NUM_RW;

  always_comb begin
    wr_sel = '0;
    for (int unsigned k = 0; k < NUM_RW; k++) begin
      wr_sel[k] = wr_fire && (32'(wr_idx) == k);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state    <= W_IDLE;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= wr_sel;
      case (w_state)
        W_IDLE: begin
          if (wr_fire) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_legal ? RESP_OKAY : RESP_SLVERR;
            w_state  <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_held  <= 1'b1;
              aw_idx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
              w_held   <= 1'b1;
              w_data_q <= S_AXI_WDATA;
              w_strb_q <= S_AXI_WSTRB;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned k = 0; k < NUM_RW; k++) begin
        regs[k] <= RST_VALUE;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_RW; k++) begin
        if (wr_sel[k]) begin
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) regs[k][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_RW; g++) begin : g_rw_out
      assign rw_regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end
  endgenerate

  assign ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:2];

  // Unmatched indices fall through to zero data with SLVERR.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b1;
    for (int unsigned k = 0; k < NUM_RW; k++) begin
      if (32'(ar_idx) == k) begin
        rd_data = regs[k];
        rd_err  = 1'b0;
      end
    end
    for (int unsigned k = 0; k < NUM_RO; k++) begin
      if (32'(ar_idx) == NUM_RW + k) begin
        rd_data = ro_regs_i[k*DATA_WIDTH +: DATA_WIDTH];
        rd_err  = 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state  <= R_IDLE;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (S_AXI_ARVALID) begin
            rdata_q  <= rd_data;
            rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            rvalid_q <= 1'b1;
            r_state  <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4l_regbank.sv
// tb/tb_axi4l_regbank.sv - self-checking bench for axi4l_regbank against a transaction-level model
module tb_axi4l_regbank;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic [5:0]   S_AXI_AWADDR = '0;
  logic [2:0]   S_AXI_AWPROT = '0;
  logic         S_AXI_AWVALID = 1'b0;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA = '0;
  logic [3:0]   S_AXI_WSTRB = '0;
  logic         S_AXI_WVALID = 1'b0;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY = 1'b0;
  logic [5:0]   S_AXI_ARADDR = '0;
  logic [2:0]   S_AXI_ARPROT = '0;
  logic         S_AXI_ARVALID = 1'b0;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY = 1'b0;
  logic [255:0] rw_regs_o;
  logic [7:0]   wr_pulse_o;
  logic [127:0] ro_regs_i = '0;

  axi4l_regbank dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .rw_regs_o(rw_regs_o), .wr_pulse_o(wr_pulse_o), .ro_regs_i(ro_regs_i)
  );

  always #5 ACLK = ~ACLK;

  int n_total = 0;
  int n_pass = 0;

  function automatic void check(string name, logic [255:0] act, logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Transaction-level model: register array, pending address/data queues, expected responses.
  logic [31:0] m_reg [8];
  int          aw_q [$];
  logic [31:0] wd_q [$];
  logic [3:0]  ws_q [$];
  bit          m_bvalid;
  logic [1:0]  m_bresp;
  logic [7:0]  m_pulse;
  bit          m_rvalid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  int          pulse_cnt [8];

  function automatic logic [255:0] model_flat();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = m_reg[k];
    return r;
  endfunction

  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        for (int k = 0; k < 8; k++) m_reg[k] = 32'h0;
        aw_q.delete(); wd_q.delete(); ws_q.delete();
        m_bvalid = 0; m_bresp = 2'b00; m_pulse = '0;
        m_rvalid = 0; m_rdata = '0; m_rresp = 2'b00;
        check("rst_awready", S_AXI_AWREADY, 1);
        check("rst_wready", S_AXI_WREADY, 1);
        check("rst_arready", S_AXI_ARREADY, 1);
        check("rst_bvalid", S_AXI_BVALID, 0);
        check("rst_rvalid", S_AXI_RVALID, 0);
        check("rst_resp", {S_AXI_BRESP, S_AXI_RRESP}, 0);
        check("rst_rdata", S_AXI_RDATA, 0);
        check("rst_pulse", wr_pulse_o, 0);
        check("rst_regs", rw_regs_o, 0);
      end else begin
        check("awready", S_AXI_AWREADY, !m_bvalid && aw_q.size() == 0);
        check("wready", S_AXI_WREADY, !m_bvalid && wd_q.size() == 0);
        check("bvalid", S_AXI_BVALID, m_bvalid);
        if (m_bvalid) check("bresp", S_AXI_BRESP, m_bresp);
        check("wr_pulse", wr_pulse_o, m_pulse);
        check("rw_regs", rw_regs_o, model_flat());
        check("arready", S_AXI_ARREADY, !m_rvalid);
        check("rvalid", S_AXI_RVALID, m_rvalid);
        if (m_rvalid) begin
          check("rdata", S_AXI_RDATA, m_rdata);
          check("rresp", S_AXI_RRESP, m_rresp);
        end
        for (int k = 0; k < 8; k++) if (wr_pulse_o[k]) pulse_cnt[k]++;
        // Read is evaluated before the write so a same-edge read sees the old value.
        if (m_rvalid) begin
          if (S_AXI_RREADY) m_rvalid = 0;
        end else if (S_AXI_ARVALID) begin
          int idx;
          idx = int'(S_AXI_ARADDR) / 4;
          if (idx < 8) begin m_rdata = m_reg[idx]; m_rresp = 2'b00; end
          else if (idx < 12) begin m_rdata = ro_regs_i[(idx-8)*32 +: 32]; m_rresp = 2'b00; end
          else begin m_rdata = '0; m_rresp = 2'b10; end
          m_rvalid = 1;
        end
        m_pulse = '0;
        if (m_bvalid) begin
          if (S_AXI_BREADY) m_bvalid = 0;
        end else begin
          if (S_AXI_AWVALID && aw_q.size() == 0) aw_q.push_back(int'(S_AXI_AWADDR) / 4);
          if (S_AXI_WVALID && wd_q.size() == 0) begin
            wd_q.push_back(S_AXI_WDATA); ws_q.push_back(S_AXI_WSTRB);
          end
          if (aw_q.size() > 0 && wd_q.size() > 0) begin
            int idx;
            logic [31:0] d;
            logic [3:0] s;
            idx = aw_q.pop_front(); d = wd_q.pop_front(); s = ws_q.pop_front();
            if (idx < 8) begin
              for (int b = 0; b < 4; b++) if (s[b]) m_reg[idx][b*8 +: 8] = d[b*8 +: 8];
              m_pulse[idx] = 1'b1;
              m_bresp = 2'b00;
            end else m_bresp = 2'b10;
            m_bvalid = 1;
          end
        end
      end
    end
  end

  task automatic write_issue(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly);
    bit aw_done = 0, w_done = 0;
    int cyc = 0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while (!(aw_done && w_done) && cyc < 200) begin
      @(posedge ACLK); #1;
      S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
      S_AXI_WVALID = !w_done && cyc >= w_dly;
      @(negedge ACLK);
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
      if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1;
      cyc++;
    end
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    check("aw_w_handshake", {aw_done, w_done}, 2'b11);
  endtask

  task automatic b_wait(input int dly, output logic [1:0] resp);
    bit done = 0;
    int cyc = 0;
    resp = 2'bxx;
    while (!done && cyc < 200) begin
      @(posedge ACLK); #1;
      S_AXI_BREADY = cyc >= dly;
      @(negedge ACLK);
      if (S_AXI_BVALID && S_AXI_BREADY) begin done = 1; resp = S_AXI_BRESP; end
      cyc++;
    end
    @(posedge ACLK); #1;
    S_AXI_BREADY = 0;
    check("b_handshake", done, 1);
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
    write_issue(addr, data, strb, aw_dly, w_dly);
    b_wait(b_dly, resp);
  endtask

  task automatic read_issue(input logic [5:0] addr, input int dly);
    bit done = 0;
    int cyc = 0;
    S_AXI_ARADDR = addr;
    while (!done && cyc < 200) begin
      @(posedge ACLK); #1;
      S_AXI_ARVALID = cyc >= dly;
      @(negedge ACLK);
      if (S_AXI_ARVALID && S_AXI_ARREADY) done = 1;
      cyc++;
    end
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 0;
    check("ar_handshake", done, 1);
  endtask

  task automatic r_wait(input int dly, output logic [31:0] data, output logic [1:0] resp);
    bit done = 0;
    int cyc = 0;
    data = 'x; resp = 'x;
    while (!done && cyc < 200) begin
      @(posedge ACLK); #1;
      S_AXI_RREADY = cyc >= dly;
      @(negedge ACLK);
      if (S_AXI_RVALID && S_AXI_RREADY) begin done = 1; data = S_AXI_RDATA; resp = S_AXI_RRESP; end
      cyc++;
    end
    @(posedge ACLK); #1;
    S_AXI_RREADY = 0;
    check("r_handshake", done, 1);
  endtask

  task automatic do_read(input logic [5:0] addr, input int ar_dly, input int r_dly,
                         output logic [31:0] data, output logic [1:0] resp);
    read_issue(addr, ar_dly);
    r_wait(r_dly, data, resp);
  endtask

  task automatic pulse_reset();
    ARESETN = 0;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [1:0]  resp, resp2;
  logic [31:0] rd;
  bit          stop_ro = 0;

  initial begin
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1;

    for (int k = 0; k < 8; k++) pulse_cnt[k] = 0;
    for (int i = 0; i < 4; i++) begin
      do_write(6'(i*4), 32'(i+1), 4'hF, 0, 0, 0, resp);
      check("t1_bresp", resp, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      do_read(6'(i*4), 0, 0, rd, resp);
      check("t1_rdata", rd, 32'(i+1));
      check("t1_rresp", resp, 2'b00);
    end
    check("t1_pulses", {pulse_cnt[0], pulse_cnt[1], pulse_cnt[2], pulse_cnt[3], pulse_cnt[4]},
          {32'd1, 32'd1, 32'd1, 32'd1, 32'd0});

    do_write(6'h00, 32'hAABBCCDD, 4'hF, 0, 0, 1, resp);
    do_write(6'h00, 32'h11223344, 4'b0101, 1, 0, 0, resp);
    do_read(6'h00, 0, 0, rd, resp);
    check("t2_merge", rd, 32'hAA22CC44);
    check("t2_pulses_reg0", pulse_cnt[0], 3);

    write_issue(6'h10, 32'h5A, 4'hF, 3, 0);
    check("t3_bvalid", S_AXI_BVALID, 1);
    check("t3_reg4", rw_regs_o[4*32 +: 32], 32'h5A);
    b_wait(0, resp);

    ro_regs_i[31:0] = 32'hDEADBEEF;
    do_read(6'h20, 0, 0, rd, resp);
    check("t4_ro_data", rd, 32'hDEADBEEF);
    check("t4_ro_resp", resp, 2'b00);
    for (int k = 0; k < 8; k++) pulse_cnt[k] = 0;
    do_write(6'h20, 32'h1234, 4'hF, 0, 0, 0, resp);
    check("t4_ro_bresp", resp, 2'b10);
    check("t4_no_pulse", pulse_cnt[0] + pulse_cnt[7], 0);
    do_read(6'h30, 0, 0, rd, resp);
    check("t4_oor_data", rd, 0);
    check("t4_oor_resp", resp, 2'b10);
    do_write(6'h3C, 32'h1, 4'hF, 0, 0, 0, resp);
    check("t4_oor_bresp", resp, 2'b10);

    write_issue(6'h14, 32'h77, 4'hF, 0, 0);
    fork
      write_issue(6'h18, 32'h88, 4'hF, 0, 0);
      begin b_wait(5, resp); b_wait(0, resp2); end
      repeat (4) begin
        @(negedge ACLK);
        check("t5_stall", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 3'b100);
      end
    join
    check("t5_reg6", rw_regs_o[6*32 +: 32], 32'h88);
    read_issue(6'h18, 0);
    repeat (5) begin
      @(negedge ACLK);
      check("t5_rhold", {S_AXI_RVALID, S_AXI_RDATA}, {1'b1, 32'h88});
    end
    r_wait(0, rd, resp);
    check("t5_rdata", rd, 32'h88);

    write_issue(6'h04, 32'h1234, 4'hF, 0, 0);
    pulse_reset();
    check("t6_bvalid", S_AXI_BVALID, 0);
    check("t6_regs", rw_regs_o, 0);
    S_AXI_AWADDR = 6'h0C; S_AXI_AWVALID = 1;
    @(negedge ACLK);
    @(posedge ACLK); #1 S_AXI_AWVALID = 0;
    check("t6_aw_held", S_AXI_AWREADY, 0);
    pulse_reset();
    do_write(6'h14, 32'hCAFE, 4'hF, 0, 0, 0, resp);
    check("t6_reg5_reg3", {rw_regs_o[5*32 +: 32], rw_regs_o[3*32 +: 32]}, {32'hCAFE, 32'h0});

    fork
      begin
        fork
          repeat (60) begin
            do_write(6'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), resp);
          end
          repeat (60) begin
            logic [31:0] rr;
            logic [1:0] rp;
            do_read(6'($urandom_range(0, 63)), $urandom_range(0, 3), $urandom_range(0, 3), rr, rp);
          end
        join
        stop_ro = 1;
      end
      while (!stop_ro) begin
        @(posedge ACLK); #1;
        ro_regs_i = {$urandom, $urandom, $urandom, $urandom};
      end
    join

    repeat (3) @(posedge ACLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
